// File: rtl/alu_seq_unit.sv
// Sequenced ALU with built-in ALUOp/Funct decode: one-cycle logic/arith, bit-serial shifts.
// Define ALU_SEQ_MULT_EN to include the WIDTH-cycle shift-add multiplier (Funct 24).
module alu_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         ALUOp,
  input  logic [5:0]         Funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_e;

`ifdef ALU_SEQ_MULT_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_e;
`endif

  function automatic op_e decode(input logic [1:0] aluop, input logic [5:0] funct);
    op_e op;
    op = OP_ILL;
    case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct)
          6'd32:   op = OP_ADD;
          6'd34:   op = OP_SUB;
          6'd36:   op = OP_AND;
          6'd37:   op = OP_OR;
          6'd38:   op = OP_XOR;
          6'd39:   op = OP_NOR;
          6'd42:   op = OP_SLT;
          6'd0:    op = OP_SLL;
          6'd2:    op = OP_SRL;
          6'd3:    op = OP_SRA;
`ifdef ALU_SEQ_MULT_EN
          6'd24:   op = OP_MUL;
`endif
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic logic [WIDTH-1:0] alu_single(input op_e op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs, ys;
    logic [WIDTH-1:0] r;
    xs = x;
    ys = y;
    r  = '0;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift1(input op_e op, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      default: r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  state_e             state_q;
  op_e                op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q, illegal_q, busy_q, done_q;

  op_e              op_d;
  logic [WIDTH-1:0] alu_d, shift_first_d, shift_nxt_d;

  assign op_d          = decode(ALUOp, Funct);
  assign alu_d         = alu_single(op_d, a, b);
  assign shift_first_d = shift1(op_d, b);
  assign shift_nxt_d   = shift1(op_q, acc_q);

`ifdef ALU_SEQ_MULT_EN
  logic [WIDTH-1:0] mcand_q, mplier_q, mul_nxt_d;
  assign mul_nxt_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // The accepting edge already performs the first shift / multiply step, so a
  // k-step operation completes k-1 edges later and k=1 finishes like a logic op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ILL;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q <= op_d;
            case (op_d)
              OP_SLL, OP_SRL, OP_SRA: begin
                if (shamt == '0) begin
                  result_q  <= b;
                  zero_q    <= (b == '0);
                  illegal_q <= 1'b0;
                  done_q    <= 1'b1;
                end else if (shamt == SHAMT_W'(1)) begin
                  result_q  <= shift_first_d;
                  zero_q    <= (shift_first_d == '0);
                  illegal_q <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  acc_q   <= shift_first_d;
                  cnt_q   <= shamt - SHAMT_W'(1);
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
                end
              end
`ifdef ALU_SEQ_MULT_EN
              OP_MUL: begin
                acc_q    <= b[0] ? a : '0;
                mcand_q  <= {a[WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, b[WIDTH-1:1]};
                cnt_q    <= SHAMT_W'(WIDTH - 1);
                busy_q   <= 1'b1;
                state_q  <= S_MUL;
              end
`endif
              OP_ILL: begin
                result_q  <= '0;
                zero_q    <= 1'b1;
                illegal_q <= 1'b1;
                done_q    <= 1'b1;
              end
              default: begin
                result_q  <= alu_d;
                zero_q    <= (alu_d == '0);
                illegal_q <= 1'b0;
                done_q    <= 1'b1;
              end
            endcase
          end
        end
        S_SHIFT: begin
          acc_q <= shift_nxt_d;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q  <= shift_nxt_d;
            zero_q    <= (shift_nxt_d == '0);
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
`ifdef ALU_SEQ_MULT_EN
        S_MUL: begin
          acc_q    <= mul_nxt_d;
          mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q  <= mul_nxt_d;
            zero_q    <= (mul_nxt_d == '0);
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (32-bit); multiply expectations follow ALU_SEQ_MULT_EN.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc;

  alu_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALUOp(ALUOp), .Funct(Funct),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op with start high for the accepting edge, then count cycles until done.
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] va,
                        input logic [31:0] vb, input logic [4:0] sh, output int n);
    ALUOp = op; Funct = fn; a = va; b = vb; shamt = sh; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 64) begin
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; ALUOp = 2'b00; Funct = 6'd0;
    a = '0; b = '0; shamt = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;
    tick();

    // slt signed: -1 < 1
    run_op(2'b10, 6'd42, 32'hFFFF_FFFF, 32'd1, 5'd0, cyc);
    chk("slt_lat", cyc, 32'd1);
    chk("slt_res", result, 32'd1);
    chk("slt_busy", {31'd0, busy}, 32'd0);

    // back-to-back add then sub
    ALUOp = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
    tick();
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_add", result, 32'd12);
    chk("b2b_zero1", {31'd0, zero}, 32'd0);
    ALUOp = 2'b01; a = 32'd7; b = 32'd7;
    tick();
    start = 1'b0;
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_sub", result, 32'd0);
    chk("b2b_zero2", {31'd0, zero}, 32'd1);
    tick();
    chk("b2b_done_off", {31'd0, done}, 32'd0);

    // sra by 4 with an ignored start mid-shift
    ALUOp = 2'b10; Funct = 6'd3; b = 32'h8000_0000; shamt = 5'd4; start = 1'b1;
    tick();
    ALUOp = 2'b00; a = 32'd1; b = 32'd1;
    chk("sra_busy1", {31'd0, busy}, 32'd1);
    chk("sra_done1", {31'd0, done}, 32'd0);
    tick();
    start = 1'b0;
    chk("sra_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("sra_busy3", {31'd0, busy}, 32'd1);
    tick();
    chk("sra_done", {31'd0, done}, 32'd1);
    chk("sra_busy_off", {31'd0, busy}, 32'd0);
    chk("sra_res", result, 32'hF800_0000);
    tick();
    chk("sra_no_extra_done", {31'd0, done}, 32'd0);
    chk("sra_res_held", result, 32'hF800_0000);

    // shift by zero, by one, and a short multi-cycle sll
    run_op(2'b10, 6'd0, 32'd0, 32'h1234_5678, 5'd0, cyc);
    chk("sll0_lat", cyc, 32'd1);
    chk("sll0_res", result, 32'h1234_5678);
    run_op(2'b10, 6'd2, 32'd0, 32'hF000_0000, 5'd1, cyc);
    chk("srl1_lat", cyc, 32'd1);
    chk("srl1_res", result, 32'h7800_0000);
    run_op(2'b10, 6'd0, 32'd0, 32'd1, 5'd3, cyc);
    chk("sll3_lat", cyc, 32'd3);
    chk("sll3_res", result, 32'd8);

    // logic ops
    run_op(2'b10, 6'd39, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, cyc);
    chk("nor_res", result, 32'hF0F0_FF00);
    run_op(2'b10, 6'd38, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, cyc);
    chk("xor_res", result, 32'h5555_5555);

    // multiply
    run_op(2'b10, 6'd24, 32'h0001_0001, 32'h0001_0001, 5'd0, cyc);
`ifdef ALU_SEQ_MULT_EN
    chk("mul_lat", cyc, 32'd32);
    chk("mul_res", result, 32'h0002_0001);
    chk("mul_illegal", {31'd0, illegal}, 32'd0);
`else
    chk("mul_lat", cyc, 32'd1);
    chk("mul_res", result, 32'd0);
    chk("mul_illegal", {31'd0, illegal}, 32'd1);
`endif

    // illegal encodings then a clearing add
    run_op(2'b11, 6'd32, 32'd3, 32'd4, 5'd0, cyc);
    chk("ill_op_lat", cyc, 32'd1);
    chk("ill_op_flag", {31'd0, illegal}, 32'd1);
    chk("ill_op_res", result, 32'd0);
    chk("ill_op_zero", {31'd0, zero}, 32'd1);
    run_op(2'b10, 6'd63, 32'd3, 32'd4, 5'd0, cyc);
    chk("ill_fn_lat", cyc, 32'd1);
    chk("ill_fn_flag", {31'd0, illegal}, 32'd1);
    run_op(2'b00, 6'd0, 32'd2, 32'd3, 5'd0, cyc);
    chk("clr_lat", cyc, 32'd1);
    chk("clr_illegal", {31'd0, illegal}, 32'd0);
    chk("clr_res", result, 32'd5);

    // async reset in the middle of a 20-step shift
    ALUOp = 2'b10; Funct = 6'd0; b = 32'd1; shamt = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_zero", {31'd0, zero}, 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, done | busy}, 32'd0);
    run_op(2'b00, 6'd0, 32'd1, 32'd1, 5'd0, cyc);
    chk("post_rst_lat", cyc, 32'd1);
    chk("post_rst_res", result, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
